adc_sar_core: RTL and testbench
===============================

# adc_sar_core

- Digital sequencer for the 12-bit SAR ADC macro; sits directly upstream of the APB ADC register interface.
- Decodes the interface's ADC_CTRL operating-mode/calibrate bits and runs power-up, offset calibration and free-running successive-approximation conversions against the analog comparator.
- Returns ADC_PWON, ADC_RDY and a held 12-bit result ADC_B to the interface.

## Interface
Parameters:
- PWON_CYCLES, 16, power-up settle cycles (1..255)
- CAL_CYCLES, 32, calibration settle cycles (1..255)
- SAMPLE_CYCLES, 2, sample/hold acquisition cycles per conversion (1..255)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; synchronous, active-high
- ADC_CTRL  in  3  {opm[1:0], cal}; opm 2'b00 = power down, any other value = run
- COMP_IN  in  1  comparator output; 1 = analog input ≥ DAC_CODE
- DAC_CODE  out  12  trial code driven to capacitive DAC
- SAMPLE  out  1  sample/hold switch enable
- CAL_SHORT  out  1  shorts ADC input to reference ground during calibration
- ADC_PWON  out  1  macro powered and settled
- ADC_RDY  out  1  calibrated, conversions valid
- ADC_B  out  12  last offset-corrected result, held between updates
- EOC  out  1  one-cycle pulse when ADC_B updates

## Operation
- States: OFF, PWUP, CAL_SETTLE, CAL_SAR, SAMPLE, CONV, DONE.
- OFF: all outputs low except ADC_B (holds). Leaves to PWUP when opm≠0.
- From any state, opm==0 sampled → OFF next cycle.
  - ADC_PWON, ADC_RDY, SAMPLE and CAL_SHORT go low on that edge.
  - A conversion in progress is aborted without updating ADC_B or pulsing EOC.
- PWUP: count PWON_CYCLES cycles, then ADC_PWON=1 and go to CAL_SETTLE. Calibration always follows power-up.
- CAL_SETTLE: CAL_SHORT=1 for CAL_CYCLES cycles, then go to CAL_SAR.
- CAL_SAR: CAL_SHORT=1 while a 12-cycle SAR runs. The result is stored in the offset register. Then ADC_RDY=1 and go to SAMPLE.
- SAMPLE: SAMPLE=1 for SAMPLE_CYCLES cycles, then go to CONV.
- CONV: 12 bit cycles, MSB first.
  - In the cycle for bit i: DAC_CODE = decided bits | (1<<i).
  - At the edge ending that cycle: bit i is kept if COMP_IN=1, otherwise cleared.
- DONE (1 cycle):
  - ADC_B = raw − offset, clamped to 0 on underflow. 12-bit unsigned; no wrap.
  - EOC=1, then return to SAMPLE (free-running).
- Recalibration:
  - A rising edge of ADC_CTRL[0], while ADC_RDY=1, sets cal_pend.
  - The current conversion completes through DONE, then the block goes to CAL_SETTLE with ADC_RDY=0.
  - cal_pend clears on entry to CAL_SETTLE. A cal edge during CAL_* is ignored.
- Offset register: cleared only by PRESET; overwritten by each calibration.
- DAC_CODE = 0 outside CONV/CAL_SAR.

## Timing
- Reset values: state OFF; DAC_CODE, ADC_B, offset = 12'h000; SAMPLE, CAL_SHORT, ADC_PWON, ADC_RDY, EOC = 0.
- All outputs are registered. ADC_CTRL and COMP_IN are sampled on the same PCLK edge.
- Edge 0 is the first edge sampling opm≠0 in OFF.
  - ADC_PWON rises at edge PWON_CYCLES.
  - ADC_RDY rises at edge PWON_CYCLES+CAL_CYCLES+12 (macro on) or PWON_CYCLES+CAL_CYCLES (macro off).
- Conversion period = SAMPLE_CYCLES+13 cycles (15 at default). The first EOC follows ADC_RDY by SAMPLE_CYCLES+13 cycles.
- ADC_B is stable for ≥14 cycles after each EOC, which satisfies the interface's 13-cycle conversion count.
- PRESET mid-operation: reset values on the next edge, regardless of state.

## Configuration
- ADC_SAR_CORE_OFFSET_CAL_EN defined:
  - CAL_SAR runs as described.
  - Offset is subtracted with clamp at 0.
- Undefined:
  - CAL_SAR is skipped; CAL_SETTLE goes directly to SAMPLE with ADC_RDY=1.
  - Offset is fixed at 0 and no offset-register logic is built.
  - ADC_B = raw.
  - CAL_SHORT is still asserted during CAL_SETTLE.

## Test plan
- Reset/power-up: PRESET, then opm=11 with defaults, macro on.
  - All outputs are 0 during reset.
  - ADC_PWON rises at edge 16; ADC_RDY rises at edge 60.
- Conversion: comparator model COMP_IN=(0xA5C ≥ DAC_CODE), offset 0.
  - Bench checks the DAC_CODE trial sequence 0x800, 0xC00, 0xA00, …
  - ADC_B=0xA5C with a one-cycle EOC, repeated every 15 cycles.
- Offset:
  - During CAL_SHORT, the model returns COMP_IN=(0x010 ≥ DAC_CODE).
  - Input 0x100 → ADC_B=0x0F0.
  - Input 0x008 → ADC_B=0x000 (clamp).
- Abort: opm→00 during CONV bit 5.
  - Next edge: ADC_PWON=ADC_RDY=0, no EOC, ADC_B keeps its prior value.
  - Re-enable repeats the full power-up and calibration.
- Recalibrate: toggle cal 0→1 mid-conversion.
  - The conversion completes with EOC.
  - ADC_RDY drops the next cycle; the new offset is applied to the following result.
- Macro off: ADC_RDY rises at edge 48, CAL_SHORT is high for 32 cycles, and ADC_B equals the raw code.

Source files
------------

// File: rtl/adc_sar_core.sv
// adc_sar_core: digital sequencer for a 12-bit SAR ADC macro.
//
// Decodes ADC_CTRL {opm[1:0], cal} and runs power-up, optional offset calibration and
// free-running successive-approximation conversions against the analog comparator.
//
// Optional feature macro: ADC_SAR_CORE_OFFSET_CAL_EN
//   defined   -> CAL_SAR state runs, offset is measured and subtracted (clamped at 0)
//   undefined -> CAL_SAR skipped, no offset register, ADC_B is the raw code
//
// Ports:
//   PCLK       in   clock, rising edge
//   PRESET     in   synchronous active-high reset
//   ADC_CTRL   in   {opm[1:0], cal}; opm == 0 powers down
//   COMP_IN    in   comparator result, 1 = analog input >= DAC_CODE
//   DAC_CODE   out  trial code to the capacitive DAC
//   SAMPLE     out  sample/hold switch enable
//   CAL_SHORT  out  input short to reference ground during calibration
//   ADC_PWON   out  macro powered and settled
//   ADC_RDY    out  calibrated, conversions valid
//   ADC_B      out  last (offset-corrected) result, held between updates
//   EOC        out  one-cycle pulse when ADC_B updates
module adc_sar_core #(
    parameter int unsigned PWON_CYCLES   = 16,
    parameter int unsigned CAL_CYCLES    = 32,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [2:0]  ADC_CTRL,
    input  logic        COMP_IN,
    output logic [11:0] DAC_CODE,
    output logic        SAMPLE,
    output logic        CAL_SHORT,
    output logic        ADC_PWON,
    output logic        ADC_RDY,
    output logic [11:0] ADC_B,
    output logic        EOC
);

    typedef enum logic [2:0] {
        StOff,
        StPwup,
        StCalSettle,
        StCalSar,
        StSample,
        StConv,
        StDone
    } state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  bit_q;
    logic [11:0] raw_q;
    logic        cal_q;
    logic        cal_pend_q;

    logic        run;
    logic        cal_rise;
    logic        last_bit;
    logic [11:0] bit_mask;
    logic [11:0] decided;
    logic [11:0] next_trial;
    logic [11:0] corrected;

    assign run      = (ADC_CTRL[2:1] != 2'b00);
    assign cal_rise = ADC_CTRL[0] & ~cal_q;
    assign last_bit = (bit_q == 4'd0);
    assign bit_mask = 12'd1 << bit_q;

    // DAC_CODE already holds the decided bits plus the bit under trial; keep or drop it.
    assign decided    = COMP_IN ? DAC_CODE : (DAC_CODE & ~bit_mask);
    assign next_trial = decided | (bit_mask >> 1);

`ifdef ADC_SAR_CORE_OFFSET_CAL_EN
    logic [11:0] offset_q;

    always_comb begin
        corrected = 12'h000;
        if (raw_q >= offset_q) begin
            corrected = raw_q - offset_q;
        end
    end
`else
    assign corrected = raw_q;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StOff;
            cnt_q      <= 8'd0;
            bit_q      <= 4'd0;
            raw_q      <= 12'h000;
            cal_q      <= 1'b0;
            cal_pend_q <= 1'b0;
            DAC_CODE   <= 12'h000;
            SAMPLE     <= 1'b0;
            CAL_SHORT  <= 1'b0;
            ADC_PWON   <= 1'b0;
            ADC_RDY    <= 1'b0;
            ADC_B      <= 12'h000;
            EOC        <= 1'b0;
`ifdef ADC_SAR_CORE_OFFSET_CAL_EN
            offset_q   <= 12'h000;
`endif
        end else begin
            cal_q <= ADC_CTRL[0];
            EOC   <= 1'b0;
            if (cal_rise && ADC_RDY) begin
                cal_pend_q <= 1'b1;
            end

            if (!run) begin
                // Power-down wins from any state; an in-flight conversion is dropped.
                state_q    <= StOff;
                DAC_CODE   <= 12'h000;
                SAMPLE     <= 1'b0;
                CAL_SHORT  <= 1'b0;
                ADC_PWON   <= 1'b0;
                ADC_RDY    <= 1'b0;
                cal_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    StOff: begin
                        state_q <= StPwup;
                        cnt_q   <= 8'd0;
                    end

                    StPwup: begin
                        if (cnt_q == 8'(PWON_CYCLES - 1)) begin
                            state_q    <= StCalSettle;
                            ADC_PWON   <= 1'b1;
                            CAL_SHORT  <= 1'b1;
                            cnt_q      <= 8'd0;
                            cal_pend_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end

                    StCalSettle: begin
                        if (cnt_q == 8'(CAL_CYCLES - 1)) begin
`ifdef ADC_SAR_CORE_OFFSET_CAL_EN
                            state_q  <= StCalSar;
                            DAC_CODE <= 12'h800;
                            bit_q    <= 4'd11;
`else
                            state_q   <= StSample;
                            CAL_SHORT <= 1'b0;
                            ADC_RDY   <= 1'b1;
                            SAMPLE    <= 1'b1;
                            cnt_q     <= 8'd0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end

`ifdef ADC_SAR_CORE_OFFSET_CAL_EN
                    StCalSar: begin
                        if (last_bit) begin
                            offset_q  <= decided;
                            DAC_CODE  <= 12'h000;
                            CAL_SHORT <= 1'b0;
                            ADC_RDY   <= 1'b1;
                            SAMPLE    <= 1'b1;
                            state_q   <= StSample;
                            cnt_q     <= 8'd0;
                        end else begin
                            DAC_CODE <= next_trial;
                            bit_q    <= bit_q - 4'd1;
                        end
                    end
`endif

                    StSample: begin
                        if (cnt_q == 8'(SAMPLE_CYCLES - 1)) begin
                            SAMPLE   <= 1'b0;
                            DAC_CODE <= 12'h800;
                            bit_q    <= 4'd11;
                            state_q  <= StConv;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end

                    StConv: begin
                        if (last_bit) begin
                            raw_q    <= decided;
                            DAC_CODE <= 12'h000;
                            state_q  <= StDone;
                        end else begin
                            DAC_CODE <= next_trial;
                            bit_q    <= bit_q - 4'd1;
                        end
                    end

                    StDone: begin
                        ADC_B <= corrected;
                        EOC   <= 1'b1;
                        cnt_q <= 8'd0;
                        // A cal request seen this very edge also counts.
                        if (cal_pend_q || (cal_rise && ADC_RDY)) begin
                            state_q    <= StCalSettle;
                            ADC_RDY    <= 1'b0;
                            CAL_SHORT  <= 1'b1;
                            cal_pend_q <= 1'b0;
                        end else begin
                            state_q <= StSample;
                            SAMPLE  <= 1'b1;
                        end
                    end

                    default: begin
                        state_q  <= StOff;
                        DAC_CODE <= 12'h000;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sar_core.sv
// Self-checking bench for adc_sar_core: table of conversion vectors, hand-written
// power-up / abort / recalibration / reset sequences, and random conversions checked
// against an arithmetic reference model. Follows ADC_SAR_CORE_OFFSET_CAL_EN if defined.
module tb_adc_sar_core;

    localparam int PwonCycles   = 16;
    localparam int CalCycles    = 32;
    localparam int SampleCycles = 2;
`ifdef ADC_SAR_CORE_OFFSET_CAL_EN
    localparam bit CalEn = 1'b1;
`else
    localparam bit CalEn = 1'b0;
`endif
    localparam int CalSarCycles = CalEn ? 12 : 0;
    localparam int RdyEdge      = PwonCycles + CalCycles + CalSarCycles;
    localparam int Period       = SampleCycles + 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ctrl;
    logic        comp_in;
    logic [11:0] dac_code;
    logic        sample;
    logic        cal_short;
    logic        pwon;
    logic        rdy;
    logic [11:0] adc_b;
    logic        eoc;

    // Analog stand-in: input voltage and the level seen while the input is shorted.
    logic [11:0] vin;
    logic [11:0] cal_lvl;
    logic [11:0] cur_cal;

    int total = 0;
    int bad   = 0;
    logic [11:0] dac_seq[$];

    assign comp_in = cal_short ? (cal_lvl >= dac_code) : (vin >= dac_code);

    always #5 clk = ~clk;

    adc_sar_core #(
        .PWON_CYCLES  (PwonCycles),
        .CAL_CYCLES   (CalCycles),
        .SAMPLE_CYCLES(SampleCycles)
    ) dut (
        .PCLK     (clk),
        .PRESET   (rst),
        .ADC_CTRL (ctrl),
        .COMP_IN  (comp_in),
        .DAC_CODE (dac_code),
        .SAMPLE   (sample),
        .CAL_SHORT(cal_short),
        .ADC_PWON (pwon),
        .ADC_RDY  (rdy),
        .ADC_B    (adc_b),
        .EOC      (eoc)
    );

    typedef struct packed {
        logic [11:0] cal_lvl;
        logic [11:0] vin;
        logic [11:0] exp_on;
    } vec_t;

    vec_t vecs[9];

    // Expected result: offset is whatever the shorted-input SAR settles to (the level itself).
    function automatic logic [11:0] model(input logic [11:0] v, input logic [11:0] lvl);
        if (!CalEn) return v;
        return (v >= lvl) ? v - lvl : 12'h000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until EOC; n = edges taken (-1 on timeout). Records DAC trials and ADC_B hold.
    task automatic wait_eoc(input int max, output int n, output bit hold_ok);
        logic [11:0] b0;
        b0 = adc_b;
        hold_ok = 1'b1;
        n = -1;
        dac_seq.delete();
        for (int k = 1; k <= max; k++) begin
            tick();
            if (eoc) begin
                n = k;
                break;
            end
            if (adc_b !== b0) hold_ok = 1'b0;
            if (dac_code != 12'h000) dac_seq.push_back(dac_code);
        end
    endtask

    task automatic power_up(input string tag);
        int pwon_e;
        int rdy_e;
        int cs_n;
        pwon_e = -1;
        rdy_e  = -1;
        cs_n   = 0;
        ctrl   = 3'b110;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (pwon && pwon_e < 0) pwon_e = k;
            if (cal_short) cs_n++;
            if (rdy) begin
                rdy_e = k;
                break;
            end
        end
        check($sformatf("%s pwon_edge", tag), pwon_e, PwonCycles);
        check($sformatf("%s rdy_edge", tag), rdy_e, RdyEdge);
        check($sformatf("%s cal_short_cycles", tag), cs_n, CalCycles + CalSarCycles);
        cur_cal = cal_lvl;
    endtask

    // Entered right after an edge that started SAMPLE; leaves right after the EOC edge.
    task automatic run_conv(input logic [11:0] v, input logic [11:0] exp, input string tag);
        int n;
        bit hold;
        vin = v;
        wait_eoc(40, n, hold);
        check($sformatf("%s eoc_latency", tag), n, Period);
        check($sformatf("%s adc_b_hold", tag), hold, 1);
        check($sformatf("%s adc_b", tag), adc_b, exp);
    endtask

    task automatic recal(input logic [11:0] lvl, input string tag);
        int n;
        bit hold;
        int rdy_k;
        logic [11:0] prev_b;
        prev_b  = adc_b;
        cal_lvl = lvl;
        repeat (5) tick();
        ctrl[0] = 1'b1;
        wait_eoc(40, n, hold);
        check($sformatf("%s eoc_completes", tag), n, Period - 5);
        check($sformatf("%s adc_b_unchanged", tag), adc_b, prev_b);
        tick();
        check($sformatf("%s rdy_drop", tag), rdy, 0);
        check($sformatf("%s cal_short", tag), cal_short, 1);
        ctrl[0] = 1'b0;
        rdy_k = -1;
        for (int k = 2; k < 120; k++) begin
            tick();
            if (rdy) begin
                rdy_k = k;
                break;
            end
        end
        check($sformatf("%s rdy_return", tag), rdy_k, CalCycles + CalSarCycles);
        cur_cal = lvl;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] d;
        logic [11:0] t;
        logic [11:0] prior_b;
        logic [11:0] v;
        int eoc_seen;
        bit found;

        vecs[0] = '{cal_lvl: 12'h000, vin: 12'hA5C, exp_on: 12'hA5C};
        vecs[1] = '{cal_lvl: 12'h000, vin: 12'h000, exp_on: 12'h000};
        vecs[2] = '{cal_lvl: 12'h000, vin: 12'hFFF, exp_on: 12'hFFF};
        vecs[3] = '{cal_lvl: 12'h000, vin: 12'h555, exp_on: 12'h555};
        vecs[4] = '{cal_lvl: 12'h010, vin: 12'h100, exp_on: 12'h0F0};
        vecs[5] = '{cal_lvl: 12'h010, vin: 12'h008, exp_on: 12'h000};
        vecs[6] = '{cal_lvl: 12'h010, vin: 12'h010, exp_on: 12'h000};
        vecs[7] = '{cal_lvl: 12'h010, vin: 12'h011, exp_on: 12'h001};
        vecs[8] = '{cal_lvl: 12'h010, vin: 12'hFFF, exp_on: 12'hFEF};

        // Reset: outputs low even with run requested.
        rst     = 1'b1;
        ctrl    = 3'b110;
        vin     = 12'hA5C;
        cal_lvl = 12'h000;
        cur_cal = 12'h000;
        repeat (3) tick();
        check("reset dac_code", dac_code, 0);
        check("reset adc_b", adc_b, 0);
        check("reset sample", sample, 0);
        check("reset cal_short", cal_short, 0);
        check("reset pwon", pwon, 0);
        check("reset rdy", rdy, 0);
        check("reset eoc", eoc, 0);
        ctrl = 3'b000;
        rst  = 1'b0;
        tick();

        power_up("pwr1");

        // First conversion: DAC trial sequence from the bisection rule.
        run_conv(12'hA5C, 12'hA5C, "conv1");
        check("conv1 trial_count", dac_seq.size(), 12);
        d = 12'h000;
        for (int i = 11; i >= 0; i--) begin
            t = d | (12'h001 << i);
            if (dac_seq.size() > 11 - i)
                check($sformatf("conv1 trial_bit%0d", i), dac_seq[11 - i], t);
            if (12'hA5C >= t) d = t;
        end
        // Second conversion also proves EOC is a single-cycle pulse and period holds.
        run_conv(12'hA5C, 12'hA5C, "conv2");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].cal_lvl != cur_cal) recal(vecs[i].cal_lvl, $sformatf("recal_vec%0d", i));
            run_conv(vecs[i].vin, CalEn ? vecs[i].exp_on : vecs[i].vin, $sformatf("vec%0d", i));
        end

        // Random conversions with occasional random recalibration.
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) recal(12'($urandom_range(0, 255)), $sformatf("rnd_recal%0d", i));
            v = 12'($urandom_range(0, 4095));
            run_conv(v, model(v, cur_cal), $sformatf("rnd%0d", i));
        end

        // Abort during CONV bit 5.
        prior_b = adc_b;
        vin     = 12'h3C7;
        found   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dac_code[5:0] == 6'b100000) begin
                found = 1'b1;
                break;
            end
        end
        check("abort bit5_reached", found, 1);
        ctrl = 3'b000;
        tick();
        check("abort pwon", pwon, 0);
        check("abort rdy", rdy, 0);
        check("abort eoc", eoc, 0);
        check("abort sample", sample, 0);
        check("abort dac_code", dac_code, 0);
        check("abort adc_b", adc_b, prior_b);
        eoc_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (eoc) eoc_seen++;
        end
        check("abort no_eoc", eoc_seen, 0);
        check("abort adc_b_held", adc_b, prior_b);

        // Re-enable: full power-up and calibration again.
        cal_lvl = 12'h020;
        power_up("pwr2");
        run_conv(12'h100, model(12'h100, cur_cal), "pwr2 conv");

        // Reset in the middle of a conversion.
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midreset adc_b", adc_b, 0);
        check("midreset pwon", pwon, 0);
        check("midreset rdy", rdy, 0);
        check("midreset dac_code", dac_code, 0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
